frame_scheduler: RTL

Frame-level controller for the detection datapath. Loads one raw frame from a pixel stream into the image RAM, then releases and paces the window sweeper. It records every dispatched window position in an outstanding-window FIFO and pairs each classifier result with its position, emitting detections. On completion it drains outstanding results and signals frame done.

---
 rtl/frame_scheduler_pkg.sv | 26 ++
 rtl/frame_scheduler_win_pos_fifo.sv | 70 +++++++
 rtl/frame_scheduler.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/frame_scheduler_pkg.sv
// Shared frame geometry, derived coordinate widths and scheduler state encoding
// for the detection datapath controller.
package frame_scheduler_pkg;

    localparam int IMG_WIDTH  = 8;
    localparam int IMG_HEIGHT = 4;
    localparam int W_X        = $clog2(IMG_WIDTH);
    localparam int W_Y        = $clog2(IMG_HEIGHT);
    localparam int W_POS      = W_X + W_Y;
    localparam int NUM_PIX    = IMG_WIDTH * IMG_HEIGHT;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SWEEP,
        ST_DRAIN,
        ST_DONE
    } sched_state_t;

    // Outstanding-window FIFO entry, x in the upper bits.
    typedef struct packed {
        logic [W_X-1:0] x;
        logic [W_Y-1:0] y;
    } win_pos_t;

endpackage

// File: rtl/frame_scheduler_win_pos_fifo.sv
// Synchronous show-ahead FIFO holding dispatched window positions until their
// classifier result returns. Supports simultaneous push and pop.
module win_pos_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push && (count_q != FULL_CNT);
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
            else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/frame_scheduler.sv
// Frame-level controller: loads a frame into image RAM, paces the window sweeper,
// pairs classifier results with window positions. Optional FRAME_SCHED_PERF_EN adds counters.
module frame_scheduler
    import frame_scheduler_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 8,
    parameter int W_PIX           = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               frame_done,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic [W_PIX-1:0]   pix_data,
    output logic               mem_we,
    output logic [W_X+W_Y-1:0] mem_waddr,
    output logic [W_PIX-1:0]   mem_wdata,
    output logic               sweep_rst,
    output logic               sweep_addr_ready,
    input  logic               cls_addr_ready,
    input  logic               win_valid,
    output logic               win_ready,
    input  logic               win_eot,
    input  logic [W_X-1:0]     win_x,
    input  logic [W_Y-1:0]     win_y,
    input  logic               res_valid,
    input  logic               res_pass,
    output logic               det_valid,
    output logic [W_X-1:0]     det_x,
    output logic [W_Y-1:0]     det_y,
    output logic               err
`ifdef FRAME_SCHED_PERF_EN
    ,
    output logic [31:0]        frame_cycles,
    output logic [31:0]        win_count,
    output logic [15:0]        det_count
`endif
);

    localparam int FAW = $clog2(MAX_OUTSTANDING);
    localparam logic [FAW:0]   CNT_ONE  = (FAW+1)'(1);
    localparam logic [W_X-1:0] LAST_COL = W_X'(IMG_WIDTH - 1);
    localparam logic [W_Y-1:0] LAST_ROW = W_Y'(IMG_HEIGHT - 1);

    sched_state_t   state_q, state_d;
    logic [W_X-1:0] col_q, col_d;
    logic [W_Y-1:0] row_q, row_d;
    logic           err_q, err_d;
    logic           det_valid_q, det_valid_d;
    logic [W_X-1:0] det_x_q, det_x_d;
    logic [W_Y-1:0] det_y_q, det_y_d;

    logic           in_sweep, in_drain;
    logic           start_frame;
    logic           win_push;
    logic           res_active, res_pop, last_pop;
    logic           fifo_full, fifo_empty;
    logic [FAW:0]   fifo_count;
    win_pos_t       fifo_din, fifo_head;

    assign in_sweep    = (state_q == ST_SWEEP);
    assign in_drain    = (state_q == ST_DRAIN);
    assign start_frame = (state_q == ST_IDLE) && start;

    assign pix_ready   = (state_q == ST_LOAD);
    assign mem_we      = pix_valid && pix_ready;
    assign mem_waddr   = {row_q, col_q};
    assign mem_wdata   = pix_data;

    assign win_ready   = in_sweep && !fifo_full;
    assign win_push    = win_valid && win_ready;
    assign fifo_din    = '{x: win_x, y: win_y};

    // Results outside SWEEP/DRAIN are dropped; an empty FIFO flags an error instead of popping.
    assign res_active  = res_valid && (in_sweep || in_drain);
    assign res_pop     = res_active && !fifo_empty;
    assign last_pop    = res_pop && (fifo_count == CNT_ONE);

    assign busy             = (state_q != ST_IDLE);
    assign frame_done       = (state_q == ST_DONE);
    assign sweep_rst        = !(in_sweep || in_drain);
    assign sweep_addr_ready = cls_addr_ready && in_sweep;

    assign det_valid = det_valid_q;
    assign det_x     = det_x_q;
    assign det_y     = det_y_q;
    assign err       = err_q;

    win_pos_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (W_POS)
    ) u_win_pos_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (start_frame),
        .push  (win_push),
        .pop   (res_pop),
        .din   (fifo_din),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        err_d       = err_q;
        det_valid_d = res_pop && res_pass;
        det_x_d     = det_x_q;
        det_y_d     = det_y_q;

        if (det_valid_d) begin
            det_x_d = fifo_head.x;
            det_y_d = fifo_head.y;
        end
        if (res_active && fifo_empty) err_d = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    col_d   = '0;
                    row_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (mem_we) begin
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        if (row_q == LAST_ROW) begin
                            row_d   = '0;
                            state_d = ST_SWEEP;
                        end else begin
                            row_d = row_q + W_Y'(1);
                        end
                    end else begin
                        col_d = col_q + W_X'(1);
                    end
                end
            end
            ST_SWEEP: begin
                if (win_eot) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Leave as soon as the final outstanding result is popped.
                if (fifo_empty || last_pop) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            err_q       <= 1'b0;
            det_valid_q <= 1'b0;
            det_x_q     <= '0;
            det_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            err_q       <= err_d;
            det_valid_q <= det_valid_d;
            det_x_q     <= det_x_d;
            det_y_q     <= det_y_d;
        end
    end

`ifdef FRAME_SCHED_PERF_EN
    logic [31:0] frame_cycles_q, frame_cycles_d;
    logic [31:0] win_count_q, win_count_d;
    logic [15:0] det_count_q, det_count_d;

    always_comb begin
        frame_cycles_d = frame_cycles_q;
        win_count_d    = win_count_q;
        det_count_d    = det_count_q;
        if (start_frame) begin
            frame_cycles_d = '0;
            win_count_d    = '0;
            det_count_d    = '0;
        end else begin
            if (state_q != ST_IDLE) frame_cycles_d = frame_cycles_q + 32'd1;
            if (win_push)           win_count_d    = win_count_q + 32'd1;
            if (det_valid_d)        det_count_d    = det_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cycles_q <= '0;
            win_count_q    <= '0;
            det_count_q    <= '0;
        end else begin
            frame_cycles_q <= frame_cycles_d;
            win_count_q    <= win_count_d;
            det_count_q    <= det_count_d;
        end
    end

    assign frame_cycles = frame_cycles_q;
    assign win_count    = win_count_q;
    assign det_count    = det_count_q;
`endif

endmodule
